// File: rtl/ahb_write_master.sv
// AHB-Lite write/read master: buffers commands in a FIFO and issues pipelined AHB transfers.
// Optional wait-state timeout is compiled in with `define AHB_WRITE_MASTER_TIMEOUT_EN.
module ahb_write_master #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        HCLK,
  input  logic        RESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [6:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        HSEL,
  output logic [6:0]  HADDR,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  output logic        HREADY,
  input  logic        HREADYOUT,
  input  logic [31:0] HRDATA,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        busy,
  output logic        err
);

  localparam int AW = $clog2(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      TIMEOUT_CYC < 1) begin : g_bad_params
    $error("ahb_write_master: unsupported parameter values");
  end

  typedef enum logic [1:0] {IDLE, ADDR, ADDR_DATA, DATA} state_t;

  state_t        state_reg, state_next;
  logic [39:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic [39:0]   head;
  logic          full, empty;
  logic          hsel, dphase, pop, push, addr_next, data_next, timeout;
  logic [6:0]    haddr_reg;
  logic          hwrite_reg;
  logic [31:0]   addr_wdata_reg;
  logic          data_write_reg;
  logic [31:0]   hwdata_reg;
  logic          rsp_valid_reg;
  logic [31:0]   rsp_rdata_reg;

  assign full  = (count_reg == (AW+1)'(FIFO_DEPTH));
  assign empty = (count_reg == '0);
  assign head  = mem[rd_ptr_reg];

  always_ff @(posedge HCLK or posedge RESET) begin
    if (RESET) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (timeout) begin
      state_next = IDLE;
    end else begin
      case ({addr_next, data_next})
        2'b00:   state_next = IDLE;
        2'b10:   state_next = ADDR;
        2'b11:   state_next = ADDR_DATA;
        default: state_next = DATA;
      endcase
    end
  end

  // Address acceptance and data completion share HREADYOUT, so one edge moves the whole pipe.
  always_comb begin
    hsel      = (state_reg == ADDR) || (state_reg == ADDR_DATA);
    dphase    = (state_reg == DATA) || (state_reg == ADDR_DATA);
    pop       = !empty && (!hsel || HREADYOUT) && !timeout;
    push      = cmd_valid && (!full || pop) && !timeout;
    addr_next = pop || (hsel && !HREADYOUT);
    data_next = HREADYOUT ? hsel : dphase;
  end

  always_ff @(posedge HCLK) begin
    if (push) mem[wr_ptr_reg] <= {cmd_write, cmd_addr, cmd_wdata};
  end

  always_ff @(posedge HCLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      haddr_reg      <= '0;
      hwrite_reg     <= 1'b0;
      addr_wdata_reg <= '0;
      data_write_reg <= 1'b0;
      hwdata_reg     <= '0;
      rsp_valid_reg  <= 1'b0;
      rsp_rdata_reg  <= '0;
    end else begin
      rsp_valid_reg <= dphase && HREADYOUT && !data_write_reg;
      if (dphase && HREADYOUT && !data_write_reg) rsp_rdata_reg <= HRDATA;
      if (hsel && HREADYOUT) begin
        data_write_reg <= hwrite_reg;
        if (hwrite_reg) hwdata_reg <= addr_wdata_reg;
      end
      if (pop) begin
        hwrite_reg     <= head[39];
        haddr_reg      <= head[38:32];
        addr_wdata_reg <= head[31:0];
        rd_ptr_reg     <= rd_ptr_reg + AW'(1);
      end
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (timeout) begin
        rd_ptr_reg <= wr_ptr_reg;
        count_reg  <= '0;
      end else begin
        count_reg <= count_reg + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end

`ifdef AHB_WRITE_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt_reg;
  logic          err_reg;

  assign timeout = dphase && !HREADYOUT && (tcnt_reg == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge HCLK or posedge RESET) begin
    if (RESET) begin
      tcnt_reg <= '0;
      err_reg  <= 1'b0;
    end else begin
      err_reg <= timeout;
      if (dphase && !HREADYOUT) tcnt_reg <= timeout ? '0 : tcnt_reg + TW'(1);
      else                      tcnt_reg <= '0;
    end
  end

  assign err = err_reg;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  assign cmd_ready = !full;
  assign HSEL      = hsel;
  assign HADDR     = haddr_reg;
  assign HWRITE    = hwrite_reg;
  assign HWDATA    = hwdata_reg;
  assign HREADY    = HREADYOUT;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign busy      = !empty || (state_reg != IDLE);

endmodule
